ex_branch_resolve: RTL
======================

# ex_branch_resolve

Execute-to-memory pipeline register with branch/jump resolution for the RV32I core. It sits directly downstream of the ALU. It takes the ALU `Result` and the four flags (`Carry`, `OverFlow`, `Zero`, `Negative`) along with decoded control. It evaluates branch conditions and produces a one-cycle PC redirect. It registers the instruction toward the memory stage over a valid/ready handshake and squashes the wrong-path instruction that follows a redirect.

## Interface
Parameters:
- `XLEN`, 32, datapath width. Only 32 is supported.

Ports:
- `clk`  in  1  single clock. All state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `in_valid`  in  1  upstream instruction valid.
- `in_ready`  out  1  block can accept this cycle.
- `in_pc`  in  32  PC of the instruction.
- `in_imm`  in  32  sign-extended immediate (B/J offset).
- `in_result`  in  32  ALU `Result`. For JALR this is rs1+imm; for branches it is rs1−rs2.
- `in_carry`, `in_overflow`, `in_zero`, `in_negative`  in  1 each  ALU flags. Carry follows the ALU convention: on SUB, 1 means no borrow.
- `in_funct3`  in  3  branch type.
- `in_branch`, `in_jal`, `in_jalr`  in  1 each  one-hot or all zero.
- `in_rd`  in  5  destination register.
- `in_reg_write`  in  1  writes rd.
- `kill`  in  1  trap flush from a later stage.
- `out_valid`  out  1  registered instruction valid.
- `out_ready`  in  1  downstream accept.
- `out_result`  out  32  ALU result, or pc+4 for JAL/JALR.
- `out_rd`  out  5  destination register.
- `out_reg_write`  out  1  writes rd.
- `redirect_valid`  out  1  one-cycle redirect pulse.
- `redirect_pc`  out  32  redirect target.
- `misaligned_exc`  out  1  present only with the macro (see Configuration).

## Operation
- Handshake:
  - `in_ready = !out_valid || out_ready`.
  - Accept on `in_valid && in_ready`.
  - Output holds stable while `out_valid && !out_ready`.
- Branch taken condition, keyed by `in_funct3`:
  - 000 BEQ: `zero`
  - 001 BNE: `!zero`
  - 100 BLT: `negative ^ overflow`
  - 101 BGE: `!(negative ^ overflow)`
  - 110 BLTU: `!carry`
  - 111 BGEU: `carry`
  - 010 and 011: not taken
- Redirect target:
  - Taken branch or JAL: `in_pc + in_imm`, mod 2^32 (wrap-around allowed).
  - JALR: `in_result & ~1`.
- `out_result`:
  - JAL/JALR: `in_pc + 4`, mod 2^32.
  - Otherwise: `in_result`.
  - Non-jump branches force `out_reg_write = 0`.
- State machine `RUN` / `SQUASH`:
  - `RUN` → `SQUASH` when the accepted instruction causes a redirect.
  - In `SQUASH`, the next accepted input completes its handshake but is discarded: no `out_valid`, no redirect. The state then returns to `RUN`.
  - `SQUASH` drops exactly one accepted instruction. It persists across cycles with no acceptance.
- `kill`:
  - Clears `out_valid` and `redirect_valid` next edge and forces state to `RUN`.
  - Any input accepted in the same cycle is dropped.
  - `kill` wins over every simultaneous event.

## Timing
- Reset values: `out_valid=0`, `redirect_valid=0`, `redirect_pc=0`, `out_result=0`, `out_rd=0`, `out_reg_write=0`, `misaligned_exc=0`, state `RUN`.
- Reset mid-operation discards the held instruction and any pending squash immediately (asynchronous).
- Latency: one cycle. An instruction accepted at edge N appears on `out_*` after edge N.
- `redirect_valid` rises after that same edge and stays high for exactly one cycle, even if `out_valid` is stalled.
- `redirect_pc` is valid only while `redirect_valid` is high.
- Back-to-back acceptance sustains throughput of 1/cycle when `out_ready` is held high.
- `in_ready` is combinational from `out_valid` and `out_ready` only. There is no path from `in_valid`.

## Configuration
- `MISALIGN_TRAP_EN` defined:
  - A redirect target with bit 1 set does not redirect.
  - Instead it raises `misaligned_exc` for one cycle alongside `out_valid`, with `out_reg_write=0`.
  - No squash follows.
- `MISALIGN_TRAP_EN` undefined:
  - The `misaligned_exc` port is absent.
  - Targets are issued unchecked.

## Test plan
- BLT: `result=FFFFFFF6`, `negative=1`, `overflow=0`, `pc=100`, `imm=20`.
  - Expect `redirect_valid=1` for one cycle, `redirect_pc=120`.
  - The next accepted instruction is squashed (no `out_valid`).
- BLTU: `carry=0`, `pc=100`, `imm=FFFFFFF0` → redirect to `F0`.
- BGEU: `carry=0` → no redirect; `out_valid=1` with `out_reg_write=0`.
- JAL: `pc=FFFFFFFC`, `imm=8`, `rd=1`.
  - Expect `out_result=00000000` (wrap) and `redirect_pc=4`.
- JALR: `result=2003`.
  - Without the macro: `redirect_pc=2002`.
  - With `MISALIGN_TRAP_EN`: `misaligned_exc=1` and no redirect.
- Hold `out_ready=0` for 3 cycles after an ADD with `result=0000000C`.
  - `in_ready=0`, outputs stable.
  - Then assert `kill` together with `in_valid`: next cycle `out_valid=0`, state `RUN`.
  - Assert `rst` during `SQUASH`: all outputs 0 immediately.

Source files
------------

// File: rtl/ex_branch_resolve.sv
// Execute-to-memory pipeline register with branch/jump resolution, PC redirect
// and wrong-path squash. Define MISALIGN_TRAP_EN to trap redirect targets with bit 1 set.
module ex_branch_resolve #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] in_pc,
  input  logic [XLEN-1:0] in_imm,
  input  logic [XLEN-1:0] in_result,
  input  logic            in_carry,
  input  logic            in_overflow,
  input  logic            in_zero,
  input  logic            in_negative,
  input  logic [2:0]      in_funct3,
  input  logic            in_branch,
  input  logic            in_jal,
  input  logic            in_jalr,
  input  logic [4:0]      in_rd,
  input  logic            in_reg_write,
  input  logic            kill,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_result,
  output logic [4:0]      out_rd,
  output logic            out_reg_write,
  output logic            redirect_valid,
  output logic [XLEN-1:0] redirect_pc
`ifdef MISALIGN_TRAP_EN
  ,
  output logic            misaligned_exc
`endif
);

  typedef enum logic {
    RUN    = 1'b0,
    SQUASH = 1'b1
  } state_e;

  state_e            state_q, state_d;
  logic              out_valid_q, out_valid_d;
  logic [XLEN-1:0]   out_result_q, out_result_d;
  logic [4:0]        out_rd_q, out_rd_d;
  logic              out_reg_write_q, out_reg_write_d;
  logic              redirect_valid_q, redirect_valid_d;
  logic [XLEN-1:0]   redirect_pc_q, redirect_pc_d;
  logic              misaligned_q, misaligned_d;

  logic              br_taken;
  logic              is_jump;
  logic              wants_redirect;
  logic              target_misaligned;
  logic              do_redirect;
  logic              accept;
  logic [XLEN-1:0]   target;
  logic [XLEN-1:0]   link_addr;

  // Flag-based condition evaluation; carry set on SUB means no borrow.
  always_comb begin
    br_taken = 1'b0;
    case (in_funct3)
      3'b000:  br_taken = in_zero;
      3'b001:  br_taken = !in_zero;
      3'b100:  br_taken = in_negative ^ in_overflow;
      3'b101:  br_taken = !(in_negative ^ in_overflow);
      3'b110:  br_taken = !in_carry;
      3'b111:  br_taken = in_carry;
      default: br_taken = 1'b0;
    endcase
  end

  assign is_jump        = in_jal || in_jalr;
  assign wants_redirect = is_jump || (in_branch && br_taken);
  assign target         = in_jalr ? (in_result & ~XLEN'(1)) : (in_pc + in_imm);
  assign link_addr      = in_pc + XLEN'(4);

`ifdef MISALIGN_TRAP_EN
  assign target_misaligned = wants_redirect && target[1];
`else
  assign target_misaligned = 1'b0;
`endif

  assign do_redirect = wants_redirect && !target_misaligned;
  assign in_ready    = !out_valid_q || out_ready;
  assign accept      = in_valid && in_ready;

  always_comb begin
    state_d          = state_q;
    out_valid_d      = out_valid_q && !out_ready;
    out_result_d     = out_result_q;
    out_rd_d         = out_rd_q;
    out_reg_write_d  = out_reg_write_q;
    redirect_valid_d = 1'b0;
    redirect_pc_d    = redirect_pc_q;
    misaligned_d     = 1'b0;

    if (kill) begin
      out_valid_d = 1'b0;
      state_d     = RUN;
    end else if (accept) begin
      if (state_q == SQUASH) begin
        // Wrong-path instruction: handshake completes, nothing is forwarded.
        state_d = RUN;
      end else begin
        out_valid_d      = 1'b1;
        out_result_d     = is_jump ? link_addr : in_result;
        out_rd_d         = in_rd;
        out_reg_write_d  = in_reg_write && !in_branch && !target_misaligned;
        redirect_valid_d = do_redirect;
        misaligned_d     = target_misaligned;
        if (do_redirect) begin
          redirect_pc_d = target;
          state_d       = SQUASH;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q          <= RUN;
      out_valid_q      <= 1'b0;
      out_result_q     <= '0;
      out_rd_q         <= '0;
      out_reg_write_q  <= 1'b0;
      redirect_valid_q <= 1'b0;
      redirect_pc_q    <= '0;
      misaligned_q     <= 1'b0;
    end else begin
      state_q          <= state_d;
      out_valid_q      <= out_valid_d;
      out_result_q     <= out_result_d;
      out_rd_q         <= out_rd_d;
      out_reg_write_q  <= out_reg_write_d;
      redirect_valid_q <= redirect_valid_d;
      redirect_pc_q    <= redirect_pc_d;
      misaligned_q     <= misaligned_d;
    end
  end

  assign out_valid      = out_valid_q;
  assign out_result     = out_result_q;
  assign out_rd         = out_rd_q;
  assign out_reg_write  = out_reg_write_q;
  assign redirect_valid = redirect_valid_q;
  assign redirect_pc    = redirect_pc_q;

`ifdef MISALIGN_TRAP_EN
  assign misaligned_exc = misaligned_q;
`else
  logic unused_misaligned;
  assign unused_misaligned = misaligned_q;
`endif

endmodule
